// File: rtl/seq_pkg.sv
// seq_pkg: state codes and successor function shared by the sequencer and the decoder; no ports
package seq_pkg;
  localparam logic [2:0] CODE_IDLE = 3'b001;
  localparam logic [2:0] CODE_S0 = 3'b010;
  localparam logic [2:0] CODE_S1 = 3'b100;
  localparam logic [2:0] CODE_S2 = 3'b110;
  localparam logic [2:0] CODE_S3 = 3'b101;
  typedef enum logic [2:0] {
    IDLE = CODE_IDLE,
    S0 = CODE_S0,
    S1 = CODE_S1,
    S2 = CODE_S2,
    S3 = CODE_S3
  } seq_state_t;
  function automatic seq_state_t next_code(seq_state_t c);
    return c == IDLE ? S0 : c == S0 ? S1 : c == S1 ? S2 : c == S2 ? S3 : IDLE;
  endfunction
endpackage

// File: rtl/state_sequencer_if.sv
// state_sequencer_if: control/status bundle; master drives start hold abort, slave drives state busy done
interface state_sequencer_if;
  logic start;
  logic hold;
  logic abort;
  logic [2:0] state;
  logic busy;
  logic done;
  modport master(output start, hold, abort, input state, busy, done);
  modport slave(input start, hold, abort, output state, busy, done);
endinterface

// File: rtl/state_sequencer_dwell_counter.sv
// dwell_counter: per-state dwell counter; in clk rst clr en terminal[CNT_W], out tc = (cnt==terminal)&en
module dwell_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] terminal,
  output logic             tc
);
  logic [CNT_W-1:0] cnt;
  assign tc = (cnt == terminal) & en;
  always_ff @(posedge clk)
    cnt <= (rst || clr || tc) ? '0 : en ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/state_sequencer.sv
// state_sequencer: one-shot IDLE->S0..S3->IDLE sequencer with per-state dwell, hold and abort; in clk rst sif(slave: start hold abort), out sif.state busy done
module state_sequencer
  import seq_pkg::*;
#(
  parameter int CNT_W    = 4,
  parameter int DWELL_S0 = 2,
  parameter int DWELL_S1 = 3,
  parameter int DWELL_S2 = 1,
  parameter int DWELL_S3 = 4
) (
  input logic clk,
  input logic rst,
  state_sequencer_if.slave sif
);
  if (DWELL_S0 < 1 || DWELL_S0 > 2**CNT_W || DWELL_S1 < 1 || DWELL_S1 > 2**CNT_W ||
      DWELL_S2 < 1 || DWELL_S2 > 2**CNT_W || DWELL_S3 < 1 || DWELL_S3 > 2**CNT_W) begin : g_bad_dwell
    $error("state_sequencer: every dwell must be in 1..2**CNT_W");
  end
  localparam logic [CNT_W-1:0] T0 = CNT_W'(DWELL_S0 - 1);
  localparam logic [CNT_W-1:0] T1 = CNT_W'(DWELL_S1 - 1);
  localparam logic [CNT_W-1:0] T2 = CNT_W'(DWELL_S2 - 1);
  localparam logic [CNT_W-1:0] T3 = CNT_W'(DWELL_S3 - 1);
  seq_state_t st;
  logic [CNT_W-1:0] term;
  logic tc;
  logic busy_q;
  logic done_q;
  always_comb begin
    term = '0;
    case (st)
      S0:      term = T0;
      S1:      term = T1;
      S2:      term = T2;
      S3:      term = T3;
      default: term = '0;
    endcase
  end
  dwell_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (st == IDLE || sif.abort),
    .en       (st != IDLE && !sif.hold),
    .terminal (term),
    .tc       (tc)
  );
  always_ff @(posedge clk)
    if (rst) begin
      st <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (st == IDLE) begin
        if (sif.start && !sif.abort) begin
          st <= S0;
          busy_q <= 1'b1;
        end
      end else if (sif.abort) begin
        st <= IDLE;
        busy_q <= 1'b0;
      end else if (tc) begin
        st <= next_code(st);
        busy_q <= st != S3;
        done_q <= st == S3;
      end
    end
  assign sif.state = st;
  assign sif.busy = busy_q;
  assign sif.done = done_q;
endmodule

// File: tb/tb_state_sequencer.sv
// tb_state_sequencer: directed bench with a phase/elapsed-time model checking two sequencer instances
module tb_state_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic hold = 1'b0;
  logic abort = 1'b0;
  always #5 clk = ~clk;
  state_sequencer_if ia ();
  state_sequencer_if ib ();
  assign ia.start = start;
  assign ia.hold = hold;
  assign ia.abort = abort;
  assign ib.start = start;
  assign ib.hold = hold;
  assign ib.abort = abort;
  state_sequencer dut_a (.clk(clk), .rst(rst), .sif(ia.slave));
  state_sequencer #(.DWELL_S2(16)) dut_b (.clk(clk), .rst(rst), .sif(ib.slave));
  int vectors = 0;
  int errors = 0;
  bit chk = 1'b0;
  logic [2:0] codes [5] = '{3'b001, 3'b010, 3'b100, 3'b110, 3'b101};
  int dw [2][5] = '{'{0, 2, 3, 1, 4}, '{0, 2, 3, 16, 4}};
  int phase [2] = '{0, 0};
  int elapsed [2] = '{0, 0};
  bit mdone [2] = '{1'b0, 1'b0};
  always @(posedge clk)
    for (int k = 0; k < 2; k++) begin
      mdone[k] = 1'b0;
      if (rst) begin
        phase[k] = 0;
        elapsed[k] = 0;
      end else if (phase[k] == 0) begin
        if (start && !abort) begin
          phase[k] = 1;
          elapsed[k] = 0;
        end
      end else if (abort) begin
        phase[k] = 0;
      end else if (!hold) begin
        elapsed[k] = elapsed[k] + 1;
        if (elapsed[k] == dw[k][phase[k]]) begin
          elapsed[k] = 0;
          phase[k] = (phase[k] + 1) % 5;
          mdone[k] = phase[k] == 0;
        end
      end
    end
  task automatic cmp(string nm, logic [2:0] got, logic [2:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b t=%0t", nm, got, exp, $time);
    end
  endtask
  function automatic logic [2:0] legal(logic [2:0] s);
    return 3'(s == 3'b001 || s == 3'b010 || s == 3'b100 || s == 3'b110 || s == 3'b101);
  endfunction
  always @(negedge clk)
    if (chk) begin
      cmp("a_state", ia.state, codes[phase[0]]);
      cmp("a_busy", 3'(ia.busy), 3'(phase[0] != 0));
      cmp("a_done", 3'(ia.done), 3'(mdone[0]));
      cmp("a_legal", legal(ia.state), 3'd1);
      cmp("b_state", ib.state, codes[phase[1]]);
      cmp("b_busy", 3'(ib.busy), 3'(phase[1] != 0));
      cmp("b_done", 3'(ib.done), 3'(mdone[1]));
      cmp("b_legal", legal(ib.state), 3'd1);
    end
  task automatic tick(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    tick(2);
    chk = 1'b1;
    cmp("rst_state", ia.state, 3'b001);
    cmp("rst_busy", 3'(ia.busy), 3'd0);
    cmp("rst_done", 3'(ia.done), 3'd0);
    rst = 1'b0;
    tick(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    cmp("s1_c1_s0", ia.state, 3'b010);
    tick();
    cmp("s1_c2_s0", ia.state, 3'b010);
    tick();
    cmp("s1_c3_s1", ia.state, 3'b100);
    tick(3);
    cmp("s1_c6_s2", ia.state, 3'b110);
    cmp("s6_c6_b_s2", ib.state, 3'b110);
    tick();
    cmp("s1_c7_s3", ia.state, 3'b101);
    tick(3);
    cmp("s1_c10_s3", ia.state, 3'b101);
    cmp("s1_c10_busy", 3'(ia.busy), 3'd1);
    tick();
    cmp("s1_c11_idle", ia.state, 3'b001);
    cmp("s1_c11_done", 3'(ia.done), 3'd1);
    cmp("s1_c11_busy", 3'(ia.busy), 3'd0);
    tick();
    cmp("s1_c12_done", 3'(ia.done), 3'd0);
    tick(9);
    cmp("s6_c21_b_s2", ib.state, 3'b110);
    tick();
    cmp("s6_c22_b_s3", ib.state, 3'b101);
    tick(4);
    cmp("s6_c26_b_idle", ib.state, 3'b001);
    cmp("s6_c26_b_done", 3'(ib.done), 3'd1);
    tick(5);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(3);
    hold = 1'b1;
    tick(3);
    hold = 1'b0;
    cmp("s2_c7_s1", ia.state, 3'b100);
    tick();
    cmp("s2_c8_s1", ia.state, 3'b100);
    tick();
    cmp("s2_c9_s2", ia.state, 3'b110);
    tick(5);
    cmp("s2_c14_done", 3'(ia.done), 3'd1);
    tick(30);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(7);
    cmp("s3_c8_s3", ia.state, 3'b101);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    cmp("s3_c9_idle", ia.state, 3'b001);
    cmp("s3_c9_done", 3'(ia.done), 3'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    cmp("s3_c10_s0", ia.state, 3'b010);
    tick(30);
    start = 1'b1;
    tick(11);
    cmp("s4_c11_done", 3'(ia.done), 3'd1);
    tick();
    cmp("s4_c12_s0", ia.state, 3'b010);
    start = 1'b0;
    tick(30);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(4);
    cmp("s5_c5_s1", ia.state, 3'b100);
    rst = 1'b1;
    hold = 1'b1;
    abort = 1'b1;
    tick();
    rst = 1'b0;
    hold = 1'b0;
    abort = 1'b0;
    cmp("s5_c6_idle", ia.state, 3'b001);
    cmp("s5_c6_busy", 3'(ia.busy), 3'd0);
    cmp("s5_c6_done", 3'(ia.done), 3'd0);
    tick(3);
    hold = 1'b1;
    start = 1'b1;
    tick();
    hold = 1'b0;
    start = 1'b0;
    cmp("idle_hold_start", ia.state, 3'b010);
    tick(30);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    cmp("idle_abort_start", ia.state, 3'b001);
    tick(3);
    chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
